// File: rtl/sobel_thresh_ctrl.sv
// Sobel edge-threshold controller.
// Produces the 11-bit threshold for the Sobel stage. Manual mode steps it with
// debounced buttons; auto mode servoes it toward a target edge count per frame.
// A new threshold is only applied at a vsync rising edge.

// Key debouncer: 2-FF synchroniser, stability counter, one-cycle press pulse.
module sobel_key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a level once it has held for DEBOUNCE_CYC cycles.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      stable    <= 1'b1;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      sync_prev <= sync2;
      press     <= 1'b0;
      if (sync2 != sync_prev) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        stable <= sync2;
        // Only the released-to-pressed transition is an event.
        press  <= stable & ~sync2;
      end
    end
  end

endmodule

module sobel_thresh_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TH_INIT      = 75,
  parameter int TH_MIN       = 10,
  parameter int TH_MAX       = 1020,
  parameter int TH_STEP      = 5,
  parameter int AUTO_STEP    = 2,
  parameter int EDGE_TGT     = 20000,
  parameter int EDGE_HYST    = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up_n,
  input  logic        key_dn_n,
  input  logic        key_mode_n,
  input  logic        sobel_vsync,
  input  logic        sobel_de,
  input  logic        sobel_data,
  output logic [10:0] key_value,
  output logic        auto_mode,
  output logic [19:0] edge_cnt
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_CNT  = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  localparam logic signed [11:0] TH_MIN_S    = signed'(12'(TH_MIN));
  localparam logic signed [11:0] TH_MAX_S    = signed'(12'(TH_MAX));
  localparam logic signed [11:0] TH_STEP_S   = signed'(12'(TH_STEP));
  localparam logic signed [11:0] AUTO_STEP_S = signed'(12'(AUTO_STEP));
  localparam logic [19:0]        EDGE_HI     = 20'(EDGE_TGT + EDGE_HYST);
  localparam logic [19:0]        EDGE_LO     = 20'(EDGE_TGT - EDGE_HYST);
  localparam logic [19:0]        CNT_MAX     = '1;

  state_t      state;
  state_t      state_nxt;
  logic        vsync_q;
  logic        rise;
  logic        up_ev;
  logic        dn_ev;
  logic        mode_ev;
  logic [10:0] pending;
  logic [10:0] pending_man;
  logic        man_upd;
  logic [10:0] auto_t;
  logic [19:0] cnt;
  logic        frame_valid;

  logic signed [11:0] pend_s;
  logic signed [11:0] man_up;
  logic signed [11:0] man_dn;
  logic signed [11:0] auto_up;
  logic signed [11:0] auto_dn;

  sobel_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_up_n),
    .press (up_ev)
  );

  sobel_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_dn_n),
    .press (dn_ev)
  );

  sobel_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_mode_n),
    .press (mode_ev)
  );

  assign rise = sobel_vsync & ~vsync_q;

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // Frame FSM next state: wait for the first vsync, then count / update per frame.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (rise) state_nxt = S_UPD;
      S_CNT:   if (rise) state_nxt = S_UPD;
      S_UPD:   state_nxt = S_CNT;
      default: state_nxt = S_WAIT;
    endcase
  end

  // Saturating threshold arithmetic, done 12-bit signed so nothing wraps.
  always_comb begin
    pend_s      = signed'({1'b0, pending});
    man_up      = pend_s + TH_STEP_S;
    man_dn      = pend_s - TH_STEP_S;
    auto_up     = pend_s + AUTO_STEP_S;
    auto_dn     = pend_s - AUTO_STEP_S;
    pending_man = pending;
    man_upd     = 1'b0;
    auto_t      = pending;
    if (!auto_mode && (up_ev != dn_ev)) begin
      man_upd = 1'b1;
      if (up_ev) pending_man = (man_up > TH_MAX_S) ? 11'(TH_MAX_S) : 11'(man_up);
      else       pending_man = (man_dn < TH_MIN_S) ? 11'(TH_MIN_S) : 11'(man_dn);
    end
    if (cnt > EDGE_HI)      auto_t = (auto_up > TH_MAX_S) ? 11'(TH_MAX_S) : 11'(auto_up);
    else if (cnt < EDGE_LO) auto_t = (auto_dn < TH_MIN_S) ? 11'(TH_MIN_S) : 11'(auto_dn);
  end

  // Datapath: edge counting, mode toggle, pending threshold and frame-boundary update.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      key_value   <= 11'(TH_INIT);
      pending     <= 11'(TH_INIT);
      auto_mode   <= 1'b0;
      edge_cnt    <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
    end else begin
      vsync_q <= sobel_vsync;
      if (mode_ev) auto_mode <= ~auto_mode;
      // Manual events never coincide with an auto update: they are gated by auto_mode.
      if (man_upd) pending <= pending_man;
      case (state)
        S_CNT: begin
          if (sobel_de && !sobel_data && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
        end
        S_UPD: begin
          edge_cnt    <= cnt;
          cnt         <= '0;
          // frame_valid is still 0 on the update that leaves S_WAIT, since it
          // is only ever set here and cleared by reset.
          frame_valid <= 1'b1;
          if (auto_mode && frame_valid) begin
            pending   <= auto_t;
            key_value <= auto_t;
          end else begin
            key_value <= pending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
